// File: rtl/pulse_peak_detector.sv
// Peak detector for shaped pulses: tracks the maximum over each above-threshold
// interval and queues one {amp, time, width, pileup} record per accepted pulse.
module pulse_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_W             = 32,
  parameter int WIDTH_W          = 8,
  parameter int MIN_WIDTH        = 3,
  parameter int MAX_WIDTH        = 40,
  parameter int HOLDOFF          = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] in_data,
  input  logic                               in_valid,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  logic                               enable,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] out_amp,
  output logic [TS_W-1:0]                    out_time,
  output logic [WIDTH_W-1:0]                 out_width,
  output logic                               out_pileup,
  output logic [15:0]                        drop_cnt,
  output logic                               busy
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int HC_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef struct packed {
    logic [SIZE_FILTER_DATA-1:0] amp;
    logic [TS_W-1:0]             t;
    logic [WIDTH_W-1:0]          w;
    logic                        pu;
  } rec_t;

  typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;

  state_t                        state, state_n;
  logic [TS_W-1:0]               ts;
  logic [WIDTH_W-1:0]            width, width_n;
  logic [HC_W-1:0]               hcnt, hcnt_n;
  logic signed [SIZE_FILTER_DATA-1:0] maxv, maxv_n;
  logic [TS_W-1:0]               pts, pts_n;
  logic                          above, push_req;

  rec_t                          mem [FIFO_DEPTH];
  logic [PW:0]                   wptr, rptr;
  logic                          full, pop, do_push, drop;
  rec_t                          head, new_rec;

  assign above = in_data > threshold;

  always_comb begin
    state_n  = state;
    width_n  = width;
    hcnt_n   = hcnt;
    maxv_n   = maxv;
    pts_n    = pts;
    push_req = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: if (enable && above) begin
          state_n = RISE;
          maxv_n  = in_data;
          pts_n   = ts;
          width_n = WIDTH_W'(1);
        end
        RISE: if (above) begin
          if (width != '1) width_n = width + 1'b1;
          // strict compare keeps the earliest timestamp among equal peaks
          if (in_data > maxv) begin
            maxv_n = in_data;
            pts_n  = ts;
          end
        end else begin
          push_req = 32'(width) >= MIN_WIDTH;
          hcnt_n   = '0;
          state_n  = (HOLDOFF == 0) ? IDLE : HOLD;
        end
        HOLD: if (32'(hcnt) + 1 >= HOLDOFF) state_n = IDLE;
              else hcnt_n = hcnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ts    <= '0;
      width <= '0;
      hcnt  <= '0;
      maxv  <= '0;
      pts   <= '0;
    end else begin
      state <= state_n;
      ts    <= ts + 1'b1;
      width <= width_n;
      hcnt  <= hcnt_n;
      maxv  <= maxv_n;
      pts   <= pts_n;
    end
  end

  // Record is built from pre-edge registers: the terminating sample never updates them.
  assign new_rec = '{amp: maxv, t: pts, w: width, pu: (32'(width) > MAX_WIDTH)};
  assign full    = (wptr - rptr) == (PW+1)'(FIFO_DEPTH);
  assign pop     = out_valid && out_ready;
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  assign head    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[PW-1:0]] <= new_rec;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign out_valid  = wptr != rptr;
  assign out_amp    = head.amp;
  assign out_time   = head.t;
  assign out_width  = head.w;
  assign out_pileup = head.pu;
  assign busy       = state != IDLE;
endmodule

// File: tb/tb_pulse_peak_detector.sv
// Scoreboard bench for pulse_peak_detector; a second instance with WIDTH_W=4
// runs in lockstep to cover width saturation.
module tb_pulse_peak_detector;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic signed [15:0] in_data = 0, threshold = 100;
  logic in_valid = 0, enable = 1, out_ready = 0;
  logic out_valid, out_pileup, busy;
  logic signed [15:0] out_amp;
  logic [31:0] out_time;
  logic [7:0]  out_width;
  logic [15:0] drop_cnt;
  logic v2, pu2, busy2;
  logic signed [15:0] amp2;
  logic [31:0] time2;
  logic [3:0]  width2;
  logic [15:0] drop2;

  pulse_peak_detector dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .threshold(threshold), .enable(enable), .out_valid(out_valid),
    .out_ready(out_ready), .out_amp(out_amp), .out_time(out_time),
    .out_width(out_width), .out_pileup(out_pileup), .drop_cnt(drop_cnt), .busy(busy));

  pulse_peak_detector #(.WIDTH_W(4)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .threshold(threshold), .enable(enable), .out_valid(v2),
    .out_ready(out_ready), .out_amp(amp2), .out_time(time2),
    .out_width(width2), .out_pileup(pu2), .drop_cnt(drop2), .busy(busy2));

  int checks = 0, errors = 0;
  logic [31:0] tb_ts;
  always @(posedge clk) if (!reset) tb_ts <= 0; else tb_ts <= tb_ts + 1;

  typedef struct {
    logic signed [15:0] amp;
    logic [31:0] t;
    int w;
    logic pu;
    int w2;
  } exp_t;
  exp_t exp_q[$];
  int exp_drop = 0;

  // Monitor: every handshake pops the oldest expected record.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record amp=%0d time=%0d width=%0d", out_amp, out_time, out_width);
      end else begin
        e = exp_q.pop_front();
        if (out_amp !== e.amp || out_time !== e.t || out_width !== 8'(e.w) ||
            out_pileup !== e.pu || v2 !== 1'b1 || amp2 !== e.amp || width2 !== 4'(e.w2) ||
            pu2 !== 1'b0) begin
          errors++;
          $display("FAIL record got amp=%0d time=%0d w=%0d pu=%0d w2=%0d want amp=%0d time=%0d w=%0d pu=%0d w2=%0d",
                   out_amp, out_time, out_width, out_pileup, width2, e.amp, e.t, e.w, e.pu, e.w2);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive(input logic signed [15:0] d, output logic [31:0] t);
    @(negedge clk);
    in_data = d; in_valid = 1; t = tb_ts;
  endtask

  task automatic push_exp(input logic signed [15:0] amp, input logic [31:0] t, input int w);
    exp_t e;
    e.amp = amp; e.t = t; e.w = (w > 255) ? 255 : w; e.pu = (w > 40); e.w2 = (w > 15) ? 15 : w;
    if (exp_q.size() >= 4 && !out_ready) exp_drop++;
    else exp_q.push_back(e);
  endtask

  task automatic pulse(input logic signed [15:0] amp, input int n, input logic signed [15:0] term);
    logic [31:0] t0, t;
    for (int i = 0; i < n; i++) begin
      drive(amp, t);
      if (i == 0) t0 = t;
    end
    drive(term, t);
    push_exp(amp, t0, n);
    repeat (8) drive(term, t);
  endtask

  task automatic wait_drain();
    @(negedge clk); out_ready = 1; in_valid = 0;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d out_valid=%0b want 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_amp, out_time, out_width, out_pileup, drop_cnt, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state v=%0b amp=%0d t=%0d w=%0d pu=%0b drop=%0d busy=%0b want all 0",
               out_valid, out_amp, out_time, out_width, out_pileup, drop_cnt, busy);
    end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_basic();
    logic [31:0] t, t300;
    threshold = 100; out_ready = 0;
    drive(0, t); drive(50, t); drive(150, t); drive(300, t300);
    @(negedge clk); in_valid = 0;
    drive(300, t); drive(200, t); drive(80, t);
    push_exp(300, t300, 4);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early out_valid=%0b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_amp !== 16'sd300) begin
      errors++; $display("FAIL basic_latency out_valid=%0b amp=%0d want 1/300", out_valid, out_amp);
    end
    repeat (8) drive(0, t);
    wait_drain();
  endtask

  task automatic test_short();
    logic [31:0] t;
    int nb = 0;
    logic signed [15:0] seq [3] = '{150, 160, 0};
    for (int i = 0; i < 12; i++) begin
      drive((i < 3) ? seq[i] : 16'sd0, t);
      @(posedge clk); #1;
      if (busy) nb++;
    end
    checks++;
    if (nb != 10) begin
      errors++; $display("FAIL short_busy cycles=%0d want 10", nb);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL short_discard out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_pileup();
    pulse(500, 45, 0);
    pulse(400, 20, 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); out_ready = 0;
    for (int i = 0; i < 6; i++) pulse(16'(1000 + i), 3, 0);
    @(negedge clk); in_valid = 0; #1;
    checks++;
    if (drop_cnt !== 16'(exp_drop) || exp_drop != 2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL fifo_full drop=%0d v=%0b want 2/1", drop_cnt, out_valid);
    end
    wait_drain();
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++; $display("FAIL drop_hold drop=%0d want 2", drop_cnt);
    end
  endtask

  task automatic test_holdoff();
    logic [31:0] t, t0, tp;
    for (int i = 0; i < 5; i++) begin
      drive(200, t);
      if (i == 0) t0 = t;
    end
    drive(0, t); push_exp(200, t0, 5);
    drive(0, t); drive(0, t);
    repeat (6) drive(250, t);
    drive(260, t); drive(270, t); drive(280, tp);
    drive(0, t); push_exp(280, tp, 3);
    repeat (8) drive(0, t);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] t;
    @(negedge clk); out_ready = 0;
    pulse(700, 3, 0);
    pulse(710, 3, 0);
    drive(800, t); drive(800, t);
    @(negedge clk); reset = 0; in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_amp, out_time, out_width, out_pileup, drop_cnt, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid v=%0b amp=%0d t=%0d w=%0d pu=%0b drop=%0d busy=%0b want all 0",
               out_valid, out_amp, out_time, out_width, out_pileup, drop_cnt, busy);
    end
    exp_q.delete(); exp_drop = 0;
    @(negedge clk); reset = 1;
    drive(0, t);
    repeat (3) begin @(negedge clk); in_valid = 0; end
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release v=%0b busy=%0b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_signed();
    logic [31:0] t;
    threshold = -50;
    @(negedge clk); enable = 0;
    repeat (3) drive(-10, t);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL enable_gate busy=%0b want 0", busy);
    end
    drive(-60, t);
    @(negedge clk); enable = 1;
    pulse(-10, 3, -60);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_pileup();
    test_back_to_back();
    test_holdoff();
    test_reset_mid();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
